pc_redirect_unit: RTL and testbench
===================================

# pc_redirect_unit

Parametrised next-PC generator and program-counter register for the fetch stage. It arbitrates between sequential fetch, ID-stage jumps, EX-stage resolved branches and traps, and generates per-stage pipeline flush masks. Redirects that arrive during a fetch stall are held and applied when the stall releases, with misaligned-target detection and a redirect performance counter. It sits between the IF-stage instruction memory address port and the IF/ID, ID/EX and EX/MEM pipeline registers.

## Interface
- XLEN, 32, address width
- RESET_VECTOR, 32'h0000_0000, PC loaded on reset
- TRAP_VECTOR, 32'h0000_0100, target for traps and misaligned redirects
- FLUSH_DEPTH, 3, number of flushable pipeline registers; bit 0 is IF/ID; must be ≥ 2
- CNT_W, 16, redirect counter width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  hold PC (hazard unit)
- branch_taken  in  1  EX-stage branch resolved taken
- branch_target  in  XLEN  branch destination
- jump  in  1  ID-stage unconditional jump
- jump_target  in  XLEN  jump destination
- trap  in  1  exception/ecall request
- pc_out  out  XLEN  current fetch address (registered)
- pc_plus4  out  XLEN  pc_out + 4, modulo 2^XLEN
- flush  out  FLUSH_DEPTH  per-stage flush mask (combinational)
- redirect  out  1  a redirect was accepted this cycle
- misalign_err  out  1  accepted branch/jump target had target[1:0] ≠ 0
- redirect_count  out  CNT_W  saturating count of accepted redirects

## Operation
- Priority, highest first: trap > branch_taken > jump > sequential.
- Misalign: if the winning source is a branch or jump and target[1:0] ≠ 0, it becomes a trap: target = TRAP_VECTOR, misalign_err = 1.
- Flush masks per winning source:
  - trap or misalign: all bits set.
  - branch: bits [1:0].
  - jump: bit 0.
  - sequential: none.
- States:
  - RUN:
    - No redirect, stall = 0: pc <= pc + 4.
    - No redirect, stall = 1: pc held.
    - Redirect, stall = 0: pc <= target.
    - Redirect, stall = 1: pending_pc <= target, go to HOLD, pc held.
  - HOLD:
    - pc held while stall = 1.
    - A trap (or misaligned branch/jump) overwrites pending_pc with TRAP_VECTOR, pulses flush with all bits set, asserts redirect and counts.
    - Plain branch/jump inputs in HOLD are wrong-path and ignored: no flush, no count.
    - When stall = 0: pc <= pending_pc (or TRAP_VECTOR if a trap is present that same cycle), go to RUN.
- redirect and flush assert in the cycle a redirect is accepted, not when pending_pc is later applied.
- redirect_count increments by 1 per accepted redirect and saturates at 2^CNT_W − 1.
- pc_plus4 derives from pc_out, not from next-PC.

## Timing
- Reset (rst_n low, asynchronous): pc_out = RESET_VECTOR, state = RUN, pending_pc = 0, redirect_count = 0. Combinational outputs (flush, redirect, misalign_err) are 0 because no requests are honoured during reset.
- Redirect latency: request sampled in cycle N (stall = 0) → pc_out = target in cycle N+1.
- Stalled redirect: pc_out = pending target in the first cycle after the cycle where stall is sampled 0.
- Flush, redirect and misalign_err are combinational from inputs and state, valid the same cycle, one pulse per acceptance.
- Reset deassertion mid-HOLD: pending target is discarded and fetch restarts at RESET_VECTOR.
- Wrap-around: pc 32'hFFFF_FFFC sequential → 32'h0000_0000.

## Test plan
- Reset then 3 free-running cycles → pc_out sequence 0x0, 0x4, 0x8, 0xC; flush = 0 throughout.
- At pc = 0x10: branch_taken with branch_target 0x40 and jump with jump_target 0x80 in the same cycle → flush = 3'b011, redirect = 1, next pc_out = 0x40, redirect_count = 1.
- stall = 1 with jump to 0x200 → flush = 3'b001 that cycle, pc held for 3 stall cycles; stall = 0 → next pc_out = 0x200.
- In HOLD (pending 0x200), trap asserted while stalled → flush = 3'b111 and pending becomes 0x100; on release, pc_out = 0x100 and redirect_count increases by exactly 2 in total.
- jump_target 0x202 → misalign_err = 1, flush = 3'b111, next pc_out = 0x100.
- Force pc to 0xFFFF_FFFC sequential → next pc_out = 0x0. With CNT_W = 2, 5 redirects → redirect_count = 3. Assert rst_n low mid-HOLD → pc_out = RESET_VECTOR immediately.

Source files
------------

// File: rtl/pc_redirect_unit.sv
// Fetch-stage next-PC arbiter and PC register: picks trap / branch / jump / sequential,
// generates per-stage flush masks and holds redirects that arrive during a fetch stall.
module pc_redirect_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int unsigned     FLUSH_DEPTH  = 3,
  parameter int unsigned     CNT_W        = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [XLEN-1:0]        branch_target,
  input  logic                   jump,
  input  logic [XLEN-1:0]        jump_target,
  input  logic                   trap,
  output logic [XLEN-1:0]        pc_out,
  output logic [XLEN-1:0]        pc_plus4,
  output logic [FLUSH_DEPTH-1:0] flush,
  output logic                   redirect,
  output logic                   misalign_err,
  output logic [CNT_W-1:0]       redirect_count
);

  localparam logic [FLUSH_DEPTH-1:0] FLUSH_NONE = '0;
  localparam logic [FLUSH_DEPTH-1:0] FLUSH_ALL  = '1;
  localparam logic [FLUSH_DEPTH-1:0] FLUSH_BR   = FLUSH_DEPTH'(2'b11);
  localparam logic [FLUSH_DEPTH-1:0] FLUSH_JMP  = FLUSH_DEPTH'(1'b1);
  localparam logic [XLEN-1:0]        PC_STEP    = XLEN'(4);
  localparam logic [CNT_W-1:0]       CNT_MAX    = '1;
  localparam logic [CNT_W-1:0]       CNT_ONE    = CNT_W'(1);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    SRC_SEQ    = 2'd0,
    SRC_JUMP   = 2'd1,
    SRC_BRANCH = 2'd2,
    SRC_TRAP   = 2'd3
  } src_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   pending_q, pending_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  src_e                  src_c;
  logic [XLEN-1:0]       target_c;
  logic                  misalign_c;
  logic                  accept_c;
  logic [FLUSH_DEPTH-1:0] mask_c;

  // Source arbitration; a misaligned branch/jump target is promoted to a trap.
  always_comb begin
    src_c      = SRC_SEQ;
    target_c   = TRAP_VECTOR;
    misalign_c = 1'b0;
    mask_c     = FLUSH_NONE;
    if (trap) begin
      src_c  = SRC_TRAP;
      mask_c = FLUSH_ALL;
    end else if (branch_taken) begin
      if (branch_target[1:0] != 2'b00) begin
        src_c      = SRC_TRAP;
        misalign_c = 1'b1;
        mask_c     = FLUSH_ALL;
      end else begin
        src_c    = SRC_BRANCH;
        target_c = branch_target;
        mask_c   = FLUSH_BR;
      end
    end else if (jump) begin
      if (jump_target[1:0] != 2'b00) begin
        src_c      = SRC_TRAP;
        misalign_c = 1'b1;
        mask_c     = FLUSH_ALL;
      end else begin
        src_c    = SRC_JUMP;
        target_c = jump_target;
        mask_c   = FLUSH_JMP;
      end
    end
  end

  // While holding, plain branches/jumps are wrong-path; only trap-class sources are taken.
  always_comb begin
    accept_c = 1'b0;
    if (rst_n) begin
      if (state_q == ST_RUN) accept_c = (src_c != SRC_SEQ);
      else                   accept_c = (src_c == SRC_TRAP);
    end
  end

  assign flush        = accept_c ? mask_c : FLUSH_NONE;
  assign redirect     = accept_c;
  assign misalign_err = accept_c & misalign_c;

  // Next-state / next-PC logic.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (accept_c) begin
          if (stall) begin
            pending_d = target_c;
            state_d   = ST_HOLD;
          end else begin
            pc_d = target_c;
          end
        end else if (!stall) begin
          pc_d = pc_q + PC_STEP;
        end
      end
      ST_HOLD: begin
        if (accept_c) pending_d = TRAP_VECTOR;
        if (!stall) begin
          pc_d    = accept_c ? TRAP_VECTOR : pending_q;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
    if (accept_c && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      pc_q      <= RESET_VECTOR;
      pending_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pc_out         = pc_q;
  assign pc_plus4       = pc_q + PC_STEP;
  assign redirect_count = cnt_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Bench for pc_redirect_unit: directed sequence with literal expectations, then
// randomized traffic checked every cycle against a behavioural fetch-PC model.
module tb_pc_redirect_unit;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, branch_taken, jump, trap;
  logic [31:0] branch_target, jump_target;

  logic [31:0] pc_out, pc_plus4, pc_out2, pc_plus42;
  logic [2:0]  flush, flush2;
  logic        redirect, misalign_err, redirect2, misalign_err2;
  logic [15:0] redirect_count;
  logic [1:0]  redirect_count2;

  int tests = 0;
  int fails = 0;

  // Model state: fetch address, held redirect, total accepted redirects.
  logic [31:0] m_pc, m_pend;
  bit          m_hold;
  int unsigned m_cnt;

  always #5 clk = ~clk;

  pc_redirect_unit dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .trap(trap),
    .pc_out(pc_out), .pc_plus4(pc_plus4), .flush(flush),
    .redirect(redirect), .misalign_err(misalign_err),
    .redirect_count(redirect_count)
  );

  pc_redirect_unit #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .trap(trap),
    .pc_out(pc_out2), .pc_plus4(pc_plus42), .flush(flush2),
    .redirect(redirect2), .misalign_err(misalign_err2),
    .redirect_count(redirect_count2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT against the model for the current cycle, then advance the model.
  task automatic model_check();
    logic [31:0] tgt;
    logic [2:0]  msk;
    bit          want, trapish, mis, acc;
    if (!rst_n) begin
      m_pc = RV; m_pend = 32'h0; m_hold = 0; m_cnt = 0;
      chk("rst_pc", pc_out, RV);
      chk("rst_redirect", 32'(redirect), 32'h0);
      return;
    end
    want = 1; trapish = 0; mis = 0; msk = 3'b000; tgt = TV;
    if (trap) begin
      trapish = 1; msk = 3'b111;
    end else if (branch_taken) begin
      if (branch_target % 4 != 0) begin trapish = 1; mis = 1; msk = 3'b111; end
      else begin tgt = branch_target; msk = 3'b011; end
    end else if (jump) begin
      if (jump_target % 4 != 0) begin trapish = 1; mis = 1; msk = 3'b111; end
      else begin tgt = jump_target; msk = 3'b001; end
    end else begin
      want = 0;
    end
    acc = m_hold ? trapish : want;

    chk("pc_out", pc_out, m_pc);
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    chk("flush", 32'(flush), acc ? 32'(msk) : 32'h0);
    chk("redirect", 32'(redirect), 32'(acc));
    chk("misalign_err", 32'(misalign_err), 32'(acc && mis));
    chk("count16", 32'(redirect_count), (m_cnt > 65535) ? 32'd65535 : m_cnt);
    chk("count2", 32'(redirect_count2), (m_cnt > 3) ? 32'd3 : m_cnt);
    chk("pc_out_cnt2", pc_out2, m_pc);

    if (acc) m_cnt++;
    if (m_hold) begin
      if (acc) m_pend = TV;
      if (!stall) begin
        m_pc   = acc ? TV : m_pend;
        m_hold = 0;
      end
    end else if (acc) begin
      if (stall) begin m_pend = tgt; m_hold = 1; end
      else m_pc = tgt;
    end else if (!stall) begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic step(input logic st, input logic bt, input logic [31:0] bta,
                      input logic jp, input logic [31:0] jta, input logic tr);
    @(posedge clk);
    #1;
    stall = st; branch_taken = bt; branch_target = bta;
    jump = jp; jump_target = jta; trap = tr;
    @(negedge clk);
    model_check();
  endtask

  task automatic idle(input logic st);
    step(st, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    logic [31:0] r;
    rst_n = 1'b0;
    stall = 0; branch_taken = 0; jump = 0; trap = 0;
    branch_target = 32'h0; jump_target = 32'h0;
    @(negedge clk);
    model_check();
    chk("lit_rst_flush", 32'(flush), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    model_check();

    // Free-running fetch
    chk("lit_pc0", pc_out, 32'h0);
    idle(0); chk("lit_pc4", pc_out, 32'h4);
    idle(0); chk("lit_pc8", pc_out, 32'h8);
    idle(0); chk("lit_pcC", pc_out, 32'hC);
    chk("lit_flush_free", 32'(flush), 32'h0);

    // Branch beats jump
    step(0, 1, 32'h40, 1, 32'h80, 0);
    chk("lit_br_pc", pc_out, 32'h10);
    chk("lit_br_flush", 32'(flush), 32'h3);
    chk("lit_br_redirect", 32'(redirect), 32'h1);

    // Jump while stalled is held, applied after release
    step(1, 0, 32'h0, 1, 32'h200, 0);
    chk("lit_br_target", pc_out, 32'h40);
    chk("lit_cnt1", 32'(redirect_count), 32'h1);
    chk("lit_jmp_flush", 32'(flush), 32'h1);
    repeat (3) begin idle(1); chk("lit_held", pc_out, 32'h40); end
    idle(0);
    idle(0); chk("lit_jmp_applied", pc_out, 32'h200);
    chk("lit_cnt2", 32'(redirect_count), 32'h2);

    // Trap in HOLD overwrites the pending target
    step(1, 0, 32'h0, 1, 32'h300, 0);
    step(1, 0, 32'h0, 0, 32'h0, 1);
    chk("lit_hold_trap_flush", 32'(flush), 32'h7);
    step(1, 1, 32'h500, 0, 32'h0, 0);
    chk("lit_hold_wrongpath", 32'(redirect), 32'h0);
    idle(0);
    idle(0); chk("lit_trap_pc", pc_out, 32'h100);
    chk("lit_cnt4", 32'(redirect_count), 32'h4);

    // Misaligned jump target
    step(0, 0, 32'h0, 1, 32'h202, 0);
    chk("lit_mis_err", 32'(misalign_err), 32'h1);
    chk("lit_mis_flush", 32'(flush), 32'h7);
    idle(0); chk("lit_mis_pc", pc_out, 32'h100);

    // Wrap-around and small-counter saturation
    step(0, 1, 32'hFFFF_FFFC, 0, 32'h0, 0);
    idle(0); chk("lit_top_pc", pc_out, 32'hFFFF_FFFC);
    chk("lit_top_plus4", pc_plus4, 32'h0);
    idle(0); chk("lit_wrap_pc", pc_out, 32'h0);
    chk("lit_cnt6", 32'(redirect_count), 32'h6);
    chk("lit_cnt2_sat", 32'(redirect_count2), 32'h3);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic bt, jp, tr, st;
      logic [31:0] bta, jta;
      st = ($urandom_range(0, 99) < 40);
      bt = ($urandom_range(0, 99) < 12);
      jp = ($urandom_range(0, 99) < 12);
      tr = ($urandom_range(0, 99) < 4);
      r = $urandom(); bta = r;
      if ($urandom_range(0, 4) != 0) bta = {r[31:2], 2'b00};
      r = $urandom(); jta = r;
      if ($urandom_range(0, 4) != 0) jta = {r[31:2], 2'b00};
      step(st, bt, bta, jp, jta, tr);
    end

    // Reset asserted mid-HOLD
    idle(0);
    step(1, 0, 32'h0, 1, 32'h400, 0);
    idle(1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("lit_midhold_rst_pc", pc_out, RV);
    chk("lit_midhold_rst_cnt", 32'(redirect_count), 32'h0);
    idle(1);
    @(posedge clk); #1;
    rst_n = 1'b1; stall = 1'b0;
    @(negedge clk);
    model_check();
    chk("lit_restart_pc", pc_out, RV);
    idle(0); chk("lit_restart_pc4", pc_out, 32'h4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
